// File: rtl/n64_responder.sv
// n64_responder: controller-side N64 serial-line responder for Reset/Status/Get commands.
// Optional synchronized-line glitch filter is enabled by defining N64_RESPONDER_GLITCH_FILTER_EN.
module n64_responder #(
  parameter int UNIT_CYCLES = 27
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Line_in,
  output logic        Line_drive_low,
  input  logic [31:0] Buttons,
  output logic [7:0]  Cmd,
  output logic        Cmd_valid,
  output logic        Busy
);

  localparam int CNT_W = $clog2(8 * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_STEP  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] T_1U_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_2U      = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] T_2U_LAST = CNT_W'(2 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_3U_LAST = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_4U_LAST = CNT_W'(4 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_8U_LAST = CNT_W'(8 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_LOW  = 3'd1,
    ST_RX_HIGH = 3'd2,
    ST_RX_STOP = 3'd3,
    ST_TURN    = 3'd4,
    ST_TX_LOW  = 3'd5,
    ST_TX_HIGH = 3'd6,
    ST_TX_STOP = 3'd7
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             line_meta_r;
  logic             line_sync_r;
  logic             line_prev_r;
  logic             line_s;
  logic             fall_s;
  logic             rise_s;
  logic [CNT_W-1:0] cnt_r;
  logic [5:0]       bit_cnt_r;
  logic [7:0]       rx_shift_r;
  logic [31:0]      tx_shift_r;
  logic [5:0]       tx_len_r;
  logic [7:0]       cmd_r;
  logic             cmd_valid_r;
  logic             drive_r;
  logic             busy_r;
  logic             drive_next_s;
  logic             busy_next_s;
  logic [CNT_W-1:0] low_last_s;
  logic [CNT_W-1:0] high_last_s;

  // Two-flop synchronizer; reset low so a line held low through reset is not seen as a fresh edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      line_meta_r <= 1'b0;
      line_sync_r <= 1'b0;
    end else begin
      line_meta_r <= Line_in;
      line_sync_r <= line_meta_r;
    end
  end

`ifdef N64_RESPONDER_GLITCH_FILTER_EN
  logic filt_h1_r;
  logic filt_h2_r;
  logic filt_r;
  logic filt_agree_s;

  assign filt_agree_s = (line_sync_r == filt_h1_r) && (filt_h1_r == filt_h2_r);

  // Filter history: the filtered level moves only after three equal synchronized samples
  always_ff @(posedge Clock) begin
    if (Reset) begin
      filt_h1_r <= 1'b0;
      filt_h2_r <= 1'b0;
      filt_r    <= 1'b0;
    end else begin
      filt_h1_r <= line_sync_r;
      filt_h2_r <= filt_h1_r;
      if (filt_agree_s) begin
        filt_r <= line_sync_r;
      end else begin
        filt_r <= filt_r;
      end
    end
  end

  assign line_s = filt_agree_s ? line_sync_r : filt_r;
`else
  assign line_s = line_sync_r;
`endif

  assign fall_s      = line_prev_r & ~line_s;
  assign rise_s      = ~line_prev_r & line_s;
  assign low_last_s  = tx_shift_r[31] ? T_1U_LAST : T_3U_LAST;
  assign high_last_s = tx_shift_r[31] ? T_3U_LAST : T_1U_LAST;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_next_s = ST_RX_LOW;
        else        state_next_s = ST_IDLE;
      end
      ST_RX_LOW: begin
        if (rise_s)                  state_next_s = ST_RX_HIGH;
        else if (cnt_r >= T_8U_LAST) state_next_s = ST_IDLE;
        else                         state_next_s = ST_RX_LOW;
      end
      ST_RX_HIGH: begin
        if (fall_s) begin
          if (bit_cnt_r == 6'd8) state_next_s = ST_RX_STOP;
          else                   state_next_s = ST_RX_LOW;
        end else if (cnt_r >= T_4U_LAST) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RX_HIGH;
        end
      end
      ST_RX_STOP: begin
        if (rise_s)                  state_next_s = ST_TURN;
        else if (cnt_r >= T_8U_LAST) state_next_s = ST_IDLE;
        else                         state_next_s = ST_RX_STOP;
      end
      ST_TURN: begin
        if (tx_len_r == 6'd0)        state_next_s = ST_IDLE;
        else if (cnt_r >= T_2U_LAST) state_next_s = ST_TX_LOW;
        else                         state_next_s = ST_TURN;
      end
      ST_TX_LOW: begin
        if (cnt_r >= low_last_s) state_next_s = ST_TX_HIGH;
        else                     state_next_s = ST_TX_LOW;
      end
      ST_TX_HIGH: begin
        if (cnt_r >= high_last_s) begin
          if (bit_cnt_r == (tx_len_r - 6'd1)) state_next_s = ST_TX_STOP;
          else                                state_next_s = ST_TX_LOW;
        end else begin
          state_next_s = ST_TX_HIGH;
        end
      end
      ST_TX_STOP: begin
        if (cnt_r >= T_2U_LAST) state_next_s = ST_IDLE;
        else                    state_next_s = ST_TX_STOP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    drive_next_s = 1'b0;
    busy_next_s  = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        drive_next_s = 1'b0;
        busy_next_s  = 1'b0;
      end
      ST_TX_LOW, ST_TX_STOP: begin
        drive_next_s = 1'b1;
        busy_next_s  = 1'b1;
      end
      default: begin
        drive_next_s = 1'b0;
        busy_next_s  = 1'b1;
      end
    endcase
  end

  // Datapath: phase timer, bit counter, shift registers and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      line_prev_r <= 1'b0;
      cnt_r       <= CNT_ZERO;
      bit_cnt_r   <= 6'd0;
      rx_shift_r  <= 8'h00;
      tx_shift_r  <= 32'h0000_0000;
      tx_len_r    <= 6'd0;
      cmd_r       <= 8'h00;
      cmd_valid_r <= 1'b0;
      drive_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      line_prev_r <= line_s;
      cmd_valid_r <= 1'b0;
      drive_r     <= drive_next_s;
      busy_r      <= busy_next_s;
      if ((state_next_s != state_r) || (state_r == ST_IDLE)) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_STEP;
      end
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r  <= 6'd0;
          rx_shift_r <= 8'h00;
        end
        ST_RX_LOW: begin
          if (rise_s) begin
            rx_shift_r <= {rx_shift_r[6:0], (cnt_r < T_2U)};
            bit_cnt_r  <= bit_cnt_r + 6'd1;
          end
        end
        ST_RX_STOP: begin
          // Buttons are captured on the same edge as the command so later changes cannot leak in
          if (rise_s) begin
            cmd_r       <= rx_shift_r;
            cmd_valid_r <= 1'b1;
            bit_cnt_r   <= 6'd0;
            case (rx_shift_r)
              8'h00, 8'hFF: begin
                tx_shift_r <= 32'h0500_0200;
                tx_len_r   <= 6'd24;
              end
              8'h01: begin
                tx_shift_r <= Buttons;
                tx_len_r   <= 6'd32;
              end
              default: begin
                tx_shift_r <= 32'h0000_0000;
                tx_len_r   <= 6'd0;
              end
            endcase
          end
        end
        ST_TX_HIGH: begin
          if (cnt_r >= high_last_s) begin
            tx_shift_r <= {tx_shift_r[30:0], 1'b0};
            bit_cnt_r  <= bit_cnt_r + 6'd1;
          end
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

  assign Line_drive_low = drive_r;
  assign Cmd            = cmd_r;
  assign Cmd_valid      = cmd_valid_r;
  assign Busy           = busy_r;

endmodule
